// File: rtl/shm_bank_scheduler_pkg.sv
// Shared types and helpers for the shared-memory bank scheduler.
// Holds the FSM state encoding, requester id sizing and one-hot decode.
package shm_bank_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int MAX_REQ = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // OR-reduction decode; only meaningful for one-hot or all-zero input.
    function automatic logic [4:0] onehot2bin(input logic [MAX_REQ-1:0] oh);
        logic [4:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) bin = bin | 5'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/shm_bank_scheduler_rr_arb_core.sv
// Round-robin pick: lowest request above the pointer, else lowest request overall.
// Latency: combinational grant; pointer moves one cycle after an update.
// Backpressure: none; caller decides when the pointer advances.
module rr_arb_core #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         upd_en,
    input  logic [N-1:0] upd_grant,
    output logic [N-1:0] grant
);

    logic [N-1:0] ptr;
    logic [N-1:0] masked;
    logic [N-1:0] pick_masked;
    logic [N-1:0] pick_any;

    always_comb begin
        masked      = req & ptr;
        pick_masked = masked & (~masked + N'(1));
        pick_any    = req & (~req + N'(1));
        grant       = (|masked) ? pick_masked : pick_any;
    end

    // Pointer keeps only the bits strictly above the last granted requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '1;
        end else if (upd_en) begin
            ptr <= ~(upd_grant | (upd_grant - N'(1)));
        end
    end

endmodule

// File: rtl/shm_bank_scheduler.sv
// Shares one single-ported SRAM bank among N requesters with burst-locked round robin.
// Latency: accept C -> mem drive C+1 -> read response C+2+MEM_LAT.
// Backpressure: one-hot req_ready per requester; responses cannot be stalled.
module shm_bank_scheduler
    import shm_bank_scheduler_pkg::*;
#(
    parameter int REQ_WIDTH = 5,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_WIDTH-1:0]        req_valid,
    input  logic [REQ_WIDTH-1:0]        req_last,
    input  logic [REQ_WIDTH-1:0]        req_we,
    input  logic [REQ_WIDTH*ADDR_W-1:0] req_addr,
    input  logic [REQ_WIDTH*DATA_W-1:0] req_wdata,
    output logic [REQ_WIDTH-1:0]        req_ready,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [REQ_WIDTH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy
);

    localparam int ID_W = id_width(REQ_WIDTH);

    typedef struct packed {
        logic              last;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    state_t                 state;
    logic [REQ_WIDTH-1:0]   owner_oh;
    logic [REQ_WIDTH-1:0]   arb_grant;
    logic [REQ_WIDTH-1:0]   grant;
    logic                   accept;
    beat_t                  beat;
    logic [ID_W-1:0]        grant_id;
    rd_tag_t                rd_pipe [MEM_LAT+1];

    rr_arb_core #(
        .N (REQ_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .upd_en    (accept & beat.last),
        .upd_grant (grant),
        .grant     (arb_grant)
    );

    // While locked only the owner may proceed; an owner gap stalls the bank.
    always_comb begin
        grant = (state == ST_IDLE) ? arb_grant : (req_valid & owner_oh);
        if (!rst) grant = '0;
        accept = |grant;
        beat   = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (grant[i]) begin
                beat.last  = req_last[i];
                beat.we    = req_we[i];
                beat.addr  = req_addr[i*ADDR_W +: ADDR_W];
                beat.wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        grant_id = ID_W'(onehot2bin(MAX_REQ'(grant)));
    end

    assign req_ready = grant;

    always_comb begin
        busy = (state == ST_LOCK);
        for (int k = 0; k <= MEM_LAT; k++) begin
            busy = busy | rd_pipe[k].vld;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner_oh  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int k = 0; k <= MEM_LAT; k++) begin
                rd_pipe[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && !beat.last) begin
                        state    <= ST_LOCK;
                        owner_oh <= grant;
                    end
                end
                ST_LOCK: begin
                    if (accept && beat.last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            mem_en <= accept;
            if (accept) begin
                mem_we    <= beat.we;
                mem_addr  <= beat.addr;
                mem_wdata <= beat.wdata;
            end

            // Stage k holds the read issued to the SRAM k cycles ago.
            rd_pipe[0] <= '{vld: accept & ~beat.we, id: grant_id};
            for (int k = 1; k <= MEM_LAT; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end

            rsp_valid <= rd_pipe[MEM_LAT].vld ? (REQ_WIDTH'(1) << rd_pipe[MEM_LAT].id) : '0;
            if (rd_pipe[MEM_LAT].vld) rsp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_shm_bank_scheduler.sv
// Directed bench for shm_bank_scheduler with a two-cycle SRAM read model.
module tb_shm_bank_scheduler;

    localparam int N   = 5;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shm_bank_scheduler #(
        .REQ_WIDTH (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // SRAM model: read data is D00D0000|addr, valid two cycles after the enable cycle.
    logic [DW-1:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= (mem_en && !mem_we) ? (32'hD00D_0000 | {22'b0, mem_addr}) : 32'hDEAD_BEEF;
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe(input int i, input logic v, input logic l, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_last[i]           = l;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state, with every requester already asking
        for (int i = 0; i < N; i++) set_pe(i, 1'b1, 1'b1, 1'b1, AW'(32'h100 + i), 32'hA0 + i);
        #2;
        check("rst_ready",     32'(req_ready), 32'h0);
        check("rst_mem_en",    32'(mem_en),    32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data",  rsp_data,       32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;

        // 1: all valid, single beats -> rotate 0,1,2,3,4,0
        for (int k = 0; k < 6; k++) begin
            check("t1_ready", 32'(req_ready), 32'(1 << (k % 5)));
            tick();
            check("t1_mem_en",    32'(mem_en),   32'h1);
            check("t1_mem_we",    32'(mem_we),   32'h1);
            check("t1_mem_addr",  32'(mem_addr), 32'h100 + (k % 5));
            check("t1_mem_wdata", mem_wdata,     32'hA0 + (k % 5));
        end
        for (int i = 0; i < N; i++) drop(i);
        #1;
        check("t1_ready_idle", 32'(req_ready), 32'h0);
        tick();
        check("t1_idle_en",   32'(mem_en),   32'h0);
        check("t1_idle_addr", 32'(mem_addr), 32'h100);
        check("t1_idle_busy", 32'(busy),     32'h0);

        // 2: PE1 four-beat burst while PE0, PE3 wait -> PE1 x4, PE3, PE0
        set_pe(0, 1'b1, 1'b1, 1'b1, 10'h0F0, 32'h0000_00F0);
        set_pe(3, 1'b1, 1'b1, 1'b1, 10'h0F3, 32'h0000_00F3);
        for (int k = 0; k < 4; k++) begin
            set_pe(1, 1'b1, (k == 3), 1'b1, AW'(32'h200 + k), 32'hB0 + k);
            #1;
            check("t2_burst_ready", 32'(req_ready), 32'b00010);
            if (k == 0) check("t2_busy_idle", 32'(busy), 32'h0);
            if (k == 2) check("t2_busy_lock", 32'(busy), 32'h1);
            tick();
            check("t2_burst_addr", 32'(mem_addr), 32'h200 + k);
        end
        drop(1);
        #1;
        check("t2_ready_pe3", 32'(req_ready), 32'b01000);
        tick();
        drop(3);
        #1;
        check("t2_ready_pe0", 32'(req_ready), 32'b00001);
        tick();
        drop(0);
        check("t2_addr_pe0", 32'(mem_addr), 32'h0F0);

        // 3: PE2 read of 0x010 -> SRAM drive next cycle, response three cycles later
        set_pe(2, 1'b1, 1'b1, 1'b0, 10'h010, 32'h0);
        #1;
        check("t3_ready", 32'(req_ready), 32'b00100);
        tick();
        drop(2);
        check("t3_mem_en",   32'(mem_en),   32'h1);
        check("t3_mem_we",   32'(mem_we),   32'h0);
        check("t3_mem_addr", 32'(mem_addr), 32'h010);
        check("t3_busy",     32'(busy),     32'h1);
        check("t3_rsp_c1",   32'(rsp_valid), 32'h0);
        tick();
        check("t3_rsp_c2", 32'(rsp_valid), 32'h0);
        tick();
        check("t3_rsp_c3", 32'(rsp_valid), 32'h0);
        tick();
        check("t3_rsp_valid", 32'(rsp_valid), 32'b00100);
        check("t3_rsp_data",  rsp_data,       32'hD00D_0010);
        tick();
        check("t3_rsp_done",  32'(rsp_valid), 32'h0);
        check("t3_busy_done", 32'(busy),      32'h0);

        // 4: PE2 again, idle five cycles, then PE0+PE4 -> PE4 first
        set_pe(2, 1'b1, 1'b1, 1'b1, 10'h022, 32'h0000_0022);
        #1;
        check("t4_ready_pe2", 32'(req_ready), 32'b00100);
        tick();
        drop(2);
        check("t4_mem_en", 32'(mem_en), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_idle_en",    32'(mem_en),    32'h0);
            check("t4_idle_ready", 32'(req_ready), 32'h0);
        end
        set_pe(0, 1'b1, 1'b1, 1'b1, 10'h040, 32'h0000_0040);
        set_pe(4, 1'b1, 1'b1, 1'b1, 10'h044, 32'h0000_0044);
        #1;
        check("t4_ready_pe4", 32'(req_ready), 32'b10000);
        tick();
        check("t4_addr_pe4", 32'(mem_addr), 32'h044);
        drop(4);
        #1;
        check("t4_ready_pe0", 32'(req_ready), 32'b00001);
        tick();
        drop(0);
        check("t4_addr_pe0", 32'(mem_addr), 32'h040);

        // 5: PE3 locked, gaps for three cycles; PE0 must wait for the burst end
        set_pe(3, 1'b1, 1'b0, 1'b1, 10'h300, 32'h0000_0300);
        set_pe(0, 1'b1, 1'b1, 1'b1, 10'h050, 32'h0000_0050);
        #1;
        check("t5_ready_b0", 32'(req_ready), 32'b01000);
        tick();
        drop(3);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_stall_ready", 32'(req_ready), 32'h0);
            check("t5_stall_busy",  32'(busy),      32'h1);
            if (k > 0) check("t5_stall_en", 32'(mem_en), 32'h0);
            tick();
        end
        set_pe(3, 1'b1, 1'b0, 1'b1, 10'h301, 32'h0000_0301);
        #1;
        check("t5_ready_b1", 32'(req_ready), 32'b01000);
        tick();
        set_pe(3, 1'b1, 1'b1, 1'b1, 10'h302, 32'h0000_0302);
        #1;
        check("t5_ready_b2", 32'(req_ready), 32'b01000);
        tick();
        check("t5_addr_b2", 32'(mem_addr), 32'h302);
        drop(3);
        #1;
        check("t5_ready_pe0", 32'(req_ready), 32'b00001);
        tick();
        drop(0);
        check("t5_addr_pe0", 32'(mem_addr), 32'h050);

        // 6: async reset mid-burst with two reads in flight
        set_pe(1, 1'b1, 1'b0, 1'b0, 10'h031, 32'h0);
        set_pe(4, 1'b1, 1'b1, 1'b1, 10'h064, 32'h0000_0064);
        #1;
        check("t6_ready_b0", 32'(req_ready), 32'b00010);
        tick();
        set_pe(1, 1'b1, 1'b0, 1'b0, 10'h032, 32'h0);
        #1;
        check("t6_ready_b1", 32'(req_ready), 32'b00010);
        tick();
        check("t6_busy_pre", 32'(busy), 32'h1);
        set_pe(1, 1'b1, 1'b1, 1'b0, 10'h033, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("t6_ready_rst",    32'(req_ready), 32'h0);
        check("t6_mem_en_rst",   32'(mem_en),    32'h0);
        check("t6_mem_addr_rst", 32'(mem_addr),  32'h0);
        check("t6_busy_rst",     32'(busy),      32'h0);
        check("t6_rsp_data_rst", rsp_data,       32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_rsp_in_rst", 32'(rsp_valid), 32'h0);
        end
        rst = 1'b1;
        drop(1);
        set_pe(0, 1'b1, 1'b1, 1'b1, 10'h070, 32'h0000_0070);
        #1;
        check("t6_ready_pe0", 32'(req_ready), 32'b00001);
        tick();
        drop(0);
        check("t6_rsp_after0", 32'(rsp_valid), 32'h0);
        #1;
        check("t6_ready_pe4", 32'(req_ready), 32'b10000);
        tick();
        drop(4);
        check("t6_rsp_after1", 32'(rsp_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_rsp_quiet", 32'(rsp_valid), 32'h0);
        end
        check("t6_busy_end", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
